// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg -- shared constants for the FIR command sequencer.
//   CMD_*          : 2-bit command codes driven on f_cmd
//   state_t        : sequencer FSM states
//   SHIFT_ADDR     : cw_addr value that targets the shift-amount register
//   STALL_CLR_ADDR : cw_addr value that clears stall_cnt (only meaningful
//                    when FIR_SEQ_STALLCNT_EN is defined)
package fir_seq_pkg;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_SEND  = 2'd3;

    localparam logic [6:0] SHIFT_ADDR     = 7'd127;
    localparam logic [6:0] STALL_CLR_ADDR = 7'd126;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_MAC,
        ST_SHIFT,
        ST_SEND
    } state_t;

endpackage

// File: rtl/fir_seq_dline.sv
// fir_seq_dline -- circular sample delay line.
//   clk, rst      : clock, synchronous active-high clear of every entry
//   we/waddr/wdata: write port (one sample per cycle)
//   raddr/rdata   : asynchronous indexed read port
module fir_seq_dline #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_seq.sv
// fir_seq -- sequences one FIR output per accepted sample by issuing a
// contiguous burst of NTAPS+2 commands to an external filter datapath:
// first-mult, NTAPS-1 MACs, shift-round, send-and-clear.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_data/in_ready: sample input handshake (ready only in IDLE)
//   cw_en/cw_addr/cw_data    : coefficient (0..NTAPS-1) / shift (127) writes
//   busy, cw_drop            : burst in progress, ignored-write pulse
//   f_push/f_cmd/f_q/f_h     : registered command stream to the filter
//   f_pushout/f_z            : filter result, re-timed onto out_valid/out_data
//   stall_cnt                : only with FIR_SEQ_STALLCNT_EN defined; counts
//                              cycles of in_valid & !in_ready, saturating,
//                              cleared by a write to address 126
module fir_seq
    import fir_seq_pkg::*;
#(
    parameter int NTAPS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        cw_en,
    input  logic [6:0]  cw_addr,
    input  logic [31:0] cw_data,
    output logic        busy,
    output logic        cw_drop,
    output logic        f_push,
    output logic [1:0]  f_cmd,
    output logic [31:0] f_q,
    output logic [31:0] f_h,
    input  logic        f_pushout,
    input  logic [31:0] f_z,
    output logic        out_valid,
    output logic [31:0] out_data
`ifdef FIR_SEQ_STALLCNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(NTAPS);

    state_t        state, state_nxt;
    logic [AW-1:0] tap, tap_nxt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rd_idx;
    logic [AW:0]   rd_sum;
    logic [31:0]   rd_data;
    logic [31:0]   coef [NTAPS];
    logic [6:0]    shift_amt;

    logic          hs;
    logic          cw_coef, cw_shift, cw_clr, cw_ok;

    logic          push_nxt;
    logic [1:0]    cmd_nxt;
    logic [31:0]   q_nxt, h_nxt;

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign hs       = in_valid & in_ready;

    // Write decode: writes land only while idle and only at known addresses.
    assign cw_coef  = (cw_addr < 7'(NTAPS));
    assign cw_shift = (cw_addr == SHIFT_ADDR);
`ifdef FIR_SEQ_STALLCNT_EN
    assign cw_clr   = (cw_addr == STALL_CLR_ADDR);
`else
    assign cw_clr   = 1'b0;
`endif
    assign cw_ok    = cw_en & in_ready & (cw_coef | cw_shift | cw_clr);

    // Next state and tap index. tap holds the index of the beat currently
    // on the f_* outputs; tap_nxt is the one being prepared.
    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_FIRST;
                    tap_nxt   = '0;
                end
            end
            ST_FIRST: begin
                state_nxt = ST_MAC;
                tap_nxt   = AW'(1);
            end
            ST_MAC: begin
                if (tap == AW'(NTAPS - 1)) state_nxt = ST_SHIFT;
                else                       tap_nxt   = tap + AW'(1);
            end
            ST_SHIFT: state_nxt = ST_SEND;
            ST_SEND:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // x[n-k] lives at wptr-1-k (wptr already advanced past x[n]); done as
    // wptr+NTAPS-1-k with one conditional subtract so any NTAPS works.
    always_comb begin
        rd_sum = {1'b0, wptr} + (AW+1)'(NTAPS - 1) - {1'b0, tap_nxt};
        if (rd_sum >= (AW+1)'(NTAPS)) rd_idx = AW'(rd_sum - (AW+1)'(NTAPS));
        else                          rd_idx = rd_sum[AW-1:0];
    end

    // Command for the next cycle, decoded from the next state so f_* are
    // plain flops. The first beat takes the sample straight from in_data
    // (not yet in the delay line) and forwards a coincident c[0] write.
    always_comb begin
        push_nxt = 1'b0;
        cmd_nxt  = CMD_FIRST;
        q_nxt    = '0;
        h_nxt    = '0;
        case (state_nxt)
            ST_FIRST: begin
                push_nxt = 1'b1;
                cmd_nxt  = CMD_FIRST;
                q_nxt    = in_data;
                h_nxt    = (cw_ok && cw_addr == 7'd0) ? cw_data : coef[0];
            end
            ST_MAC: begin
                push_nxt = 1'b1;
                cmd_nxt  = CMD_MAC;
                q_nxt    = rd_data;
                h_nxt    = coef[tap_nxt];
            end
            ST_SHIFT: begin
                push_nxt = 1'b1;
                cmd_nxt  = CMD_SHIFT;
                h_nxt    = {25'd0, shift_amt};
            end
            ST_SEND: begin
                push_nxt = 1'b1;
                cmd_nxt  = CMD_SEND;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tap   <= '0;
            wptr  <= '0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
            if (hs) wptr <= (wptr == AW'(NTAPS - 1)) ? '0 : wptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
            shift_amt <= '0;
            cw_drop   <= 1'b0;
        end else begin
            if (cw_ok && cw_coef)  coef[cw_addr[AW-1:0]] <= cw_data;
            if (cw_ok && cw_shift) shift_amt <= cw_data[6:0];
            cw_drop <= cw_en & ~cw_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_push    <= 1'b0;
            f_cmd     <= CMD_FIRST;
            f_q       <= '0;
            f_h       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            f_push    <= push_nxt;
            f_cmd     <= cmd_nxt;
            f_q       <= q_nxt;
            f_h       <= h_nxt;
            out_valid <= f_pushout;
            if (f_pushout) out_data <= f_z;
        end
    end

`ifdef FIR_SEQ_STALLCNT_EN
    always_ff @(posedge clk) begin
        if (rst || (cw_ok && cw_clr)) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    fir_seq_dline #(
        .DEPTH (NTAPS),
        .W     (32),
        .AW    (AW)
    ) u_dline (
        .clk   (clk),
        .rst   (rst),
        .we    (hs),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

endmodule

// File: doc/fir_seq.md
FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 SHALL have parameter NTAPS, default 8, taps per output sample (legal 2..64).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  input sample offered.
- in_data  in  32  signed input sample.
- in_ready  out  1  sample accepted when in_valid&in_ready.
- cw_en  in  1  coefficient/shift write strobe.
- cw_addr  in  7  0..NTAPS-1 selects coefficient; 127 selects shift amount.
- cw_data  in  32  write data (shift uses bits [6:0]).
- busy  out  1  burst in progress.
- cw_drop  out  1  one-cycle pulse: write ignored.
- f_push  out  1  command push to filter.
- f_cmd  out  2  0 first-mult, 1 MAC, 2 shift-round, 3 send-and-clear.
- f_q  out  32  sample operand.
- f_h  out  32  coefficient or shift operand.
- f_pushout  in  1  filter result valid.
- f_z  in  32  filter result.
- out_valid  out  1  result valid.
- out_data  out  32  result.

Function
REQ-003 SHALL implement FSM IDLE -> FIRST -> MAC -> SHIFT -> SEND -> IDLE.
REQ-004 SHALL assert in_ready combinationally only in IDLE; busy = not IDLE.
REQ-005 On handshake in cycle T SHALL write in_data into a circular NTAPS-deep delay line at wptr, advance wptr (NTAPS-1 wraps to 0), enter FIRST.
REQ-006 f_push/f_cmd/f_q/f_h SHALL be registered; f_push high exactly NTAPS+2 cycles per sample, contiguous, zero otherwise.
REQ-007 Cycle T+1: cmd 0, f_q=x[n], f_h=c[0].
REQ-008 Cycles T+2..T+NTAPS: cmd 1, tap k=1..NTAPS-1, f_q=x[n-k] (delay-line index modulo NTAPS), f_h=c[k].
REQ-009 Cycle T+NTAPS+1: cmd 2, f_q=0, f_h=zero-extended shift[6:0].
REQ-010 Cycle T+NTAPS+2: cmd 3, f_q=0, f_h=0; in_ready high again from T+NTAPS+3.
REQ-011 f_q/f_h SHALL be 0 whenever f_push is 0.
REQ-012 cw_en in IDLE SHALL write next cycle; cw_en while busy, or addr in NTAPS..126, SHALL be ignored and pulse cw_drop next cycle.
REQ-013 cw_en coincident with an IDLE handshake SHALL be written; the burst SHALL use the new value.
REQ-014 out_valid/out_data SHALL equal f_pushout/f_z delayed one cycle; out_data holds last value when out_valid low.
REQ-015 Tap-counter SHALL be width clog2(NTAPS); no arithmetic on data, widths pass through unchanged.

Reset
REQ-016 On rst: FSM IDLE, wptr 0, delay line, coefficients and shift zeroed, all outputs 0 except in_ready=1 (combinational from IDLE) after reset releases.
REQ-017 rst mid-burst SHALL abort: f_push low next cycle, no further commands issued.

Configuration
REQ-018 With FIR_SEQ_STALLCNT_EN defined: extra output stall_cnt (16 bits) counts cycles with in_valid&!in_ready, saturating at 65535, cleared by rst and by cw_write to addr 126 (not dropped in that case).
REQ-019 Without FIR_SEQ_STALLCNT_EN: port and counter absent; addr 126 is an ignored address (cw_drop).

Structure
REQ-020 Package fir_seq_pkg SHALL hold cmd code constants (CMD_FIRST, CMD_MAC, CMD_SHIFT, CMD_SEND), FSM state enum, SHIFT_ADDR=127.
REQ-021 Sub-module fir_seq_dline SHALL implement the circular delay line (write port, indexed read port, sync clear).

Verification
REQ-022 NTAPS=4, c={1,2,3,4}, shift=0, push 5 -> cmd trace 0/1/1/1/2/3 with f_q 5,0,0,0,0,0 and f_h 1,2,3,4,0,0.
REQ-023 Samples 1,2,3,4,5 back-to-back -> 5th burst f_q 5,4,3,2, in_ready low 6 cycles per sample.
REQ-024 cw_en addr 2 while busy -> cw_drop pulse, next burst still uses old c[2].
REQ-025 shift=7 -> cmd-2 beat f_h=0x00000007; f_pushout=1,f_z=0x1234 -> out_valid=1,out_data=0x1234 one cycle later.
REQ-026 rst asserted at third MAC beat -> f_push 0 next cycle, delay line reads zero on next burst.
REQ-027 FIR_SEQ_STALLCNT_EN, in_valid held 100 cycles with NTAPS=8 -> stall_cnt equals counted busy-overlap cycles; write addr 126 clears it.
